// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, branch flushes, and a supervised data-memory freeze.
// Optional HAZ_PERF_CNT_EN adds free-running stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] ifid_rs1_i,
  input  logic [REG_W-1:0] ifid_rs2_i,
  input  logic             ifid_uses_rs2_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             if_stall_o,
  output logic             if_flush_o,
  output logic             id_bubble_o,
  output logic             mem_stall_o,
  output logic             mem_start_o,
  output logic             err_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      flush_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic w_hazard;
  logic w_mem_freeze;
  logic w_run_rules;

  assign w_hazard = idex_memread_i && (idex_rd_i != '0) &&
                    ((idex_rd_i == ifid_rs1_i) ||
                     (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));

  // A zero-wait hit (req and ack together) never freezes the pipeline.
  assign w_mem_freeze = dmem_req_i && !dmem_ack_i;

  always_comb begin
    w_run_rules = 1'b0;
    pc_write_o  = 1'b0;
    if_stall_o  = 1'b0;
    if_flush_o  = 1'b0;
    id_bubble_o = 1'b0;
    mem_stall_o = 1'b0;
    mem_start_o = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mem_freeze) begin
          mem_stall_o = 1'b1;
          mem_start_o = 1'b1;
        end else begin
          w_run_rules = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_ack_i) w_run_rules = 1'b1;
        else            mem_stall_o = 1'b1;
      end
      S_HALT:  mem_stall_o = 1'b1;
      default: ;
    endcase
    // Load-use wins over a taken branch; ID re-resolves the branch after the bubble.
    if (w_run_rules) begin
      if (w_hazard) begin
        if_stall_o  = 1'b1;
        id_bubble_o = 1'b1;
      end else begin
        pc_write_o = 1'b1;
        if_flush_o = branch_taken_i;
      end
    end
  end

  assign err_o = r_err;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) r_state <= S_RUN;
        S_RUN: begin
          if (w_mem_freeze) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else if (!start_i) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (dmem_ack_i) begin
            r_state <= S_RUN;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (((r_state == S_RUN) || (r_state == S_WAIT)) && !pc_write_o)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (if_flush_o)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0, idex_memread_i = 1'b0, ifid_uses_rs2_i = 1'b0;
  logic [4:0] idex_rd_i = '0, ifid_rs1_i = '0, ifid_rs2_i = '0;
  logic       branch_taken_i = 1'b0, dmem_req_i = 1'b0, dmem_ack_i = 1'b0;
  logic       pc_write_o, if_stall_o, if_flush_o, id_bubble_o, mem_stall_o, mem_start_o, err_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int ncmp = 0;
  int nfail = 0;

  pipe_hazard_ctrl #(.REG_W(5), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i), .ifid_uses_rs2_i(ifid_uses_rs2_i),
    .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .pc_write_o(pc_write_o), .if_stall_o(if_stall_o), .if_flush_o(if_flush_o),
    .id_bubble_o(id_bubble_o), .mem_stall_o(mem_stall_o), .mem_start_o(mem_start_o),
    .err_o(err_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Observed outputs: {pc_write, if_stall, if_flush, id_bubble, mem_stall, mem_start, err}
  logic [6:0] obs;
  assign obs = {pc_write_o, if_stall_o, if_flush_o, id_bubble_o, mem_stall_o, mem_start_o, err_o};

  // Reference model: running / waiting-on-memory / halted flags and cycles waited.
  bit m_run, m_wait, m_halt, m_err;
  int m_waited;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_run = 0; m_wait = 0; m_halt = 0; m_err = 0; m_waited = 0;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (m_wait) begin
      if (dmem_ack_i) begin
        m_wait = 0; m_run = 1;
      end else begin
        m_waited = m_waited + 1;
        if (m_waited >= TO) begin m_wait = 0; m_halt = 1; m_err = 1; end
      end
    end else if (m_run) begin
      if (dmem_req_i && !dmem_ack_i) begin m_run = 0; m_wait = 1; m_waited = 0; end
      else if (!start_i) m_run = 0;
    end else if (start_i) begin
      m_run = 1;
    end
  end

  function automatic logic [6:0] model_out();
    logic [6:0] o;
    logic hz;
    o = '0;
    hz = idex_memread_i && (idex_rd_i != 0) &&
         ((idex_rd_i == ifid_rs1_i) || (ifid_uses_rs2_i && idex_rd_i == ifid_rs2_i));
    if (rst_i) return '0;
    o[0] = m_err;
    if (m_halt || (m_wait && !dmem_ack_i)) o[2] = 1'b1;
    else if (m_run && dmem_req_i && !dmem_ack_i) o[2:1] = 2'b11;
    else if (m_run || m_wait) begin
      if (hz) begin o[5] = 1'b1; o[3] = 1'b1; end
      else begin o[6] = 1'b1; o[4] = branch_taken_i; end
    end
    return o;
  endfunction

  task automatic drive(input logic st, mr, input logic [4:0] rd, rs1, rs2,
                       input logic u2, br, rq, ak);
    @(negedge clk);
    start_i = st; idex_memread_i = mr; idex_rd_i = rd; ifid_rs1_i = rs1;
    ifid_rs2_i = rs2; ifid_uses_rs2_i = u2; branch_taken_i = br;
    dmem_req_i = rq; dmem_ack_i = ak;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ncmp++; if (obs !== 7'b0) begin nfail++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0); end
    @(negedge clk); rst_i = 1'b0; #1;
    ncmp++; if (obs !== 7'b0) begin nfail++; $display("FAIL idle_outputs: got %b want %b", obs, 7'b0); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ncmp++; if (obs !== 7'b1000000) begin nfail++; $display("FAIL first_run: got %b want %b", obs, 7'b1000000); end
    drive(1, 0, 3, 1, 2, 1, 0, 0, 0);
    ncmp++; if (obs !== model_out()) begin nfail++; $display("FAIL run_idle_traffic: got %b want %b", obs, model_out()); end
  endtask

  task automatic test_load_use();
    drive(1, 1, 5, 0, 5, 1, 0, 0, 0);
    ncmp++; if ({pc_write_o, if_stall_o, id_bubble_o} !== 3'b011) begin nfail++;
      $display("FAIL load_use_rs2: got pc/stall/bubble=%b want 011", {pc_write_o, if_stall_o, id_bubble_o}); end
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0);
    ncmp++; if ({pc_write_o, if_stall_o, id_bubble_o} !== 3'b100) begin nfail++;
      $display("FAIL load_use_rd0: got pc/stall/bubble=%b want 100", {pc_write_o, if_stall_o, id_bubble_o}); end
    drive(1, 1, 7, 7, 1, 0, 0, 0, 0);
    ncmp++; if (if_stall_o !== 1'b1) begin nfail++; $display("FAIL load_use_rs1: got %b want 1", if_stall_o); end
    drive(1, 1, 9, 1, 9, 0, 0, 0, 0);
    ncmp++; if (if_stall_o !== 1'b0) begin nfail++; $display("FAIL rs2_unused: got %b want 0", if_stall_o); end
    drive(1, 0, 9, 9, 9, 1, 0, 0, 0);
    ncmp++; if (obs !== model_out()) begin nfail++; $display("FAIL not_a_load: got %b want %b", obs, model_out()); end
  endtask

  task automatic test_hazard_branch();
    drive(1, 1, 4, 4, 0, 0, 1, 0, 0);
    ncmp++; if ({if_stall_o, if_flush_o, pc_write_o} !== 3'b100) begin nfail++;
      $display("FAIL hazard_beats_branch: got stall/flush/pc=%b want 100", {if_stall_o, if_flush_o, pc_write_o}); end
    drive(1, 0, 4, 4, 0, 0, 1, 0, 0);
    ncmp++; if ({if_flush_o, pc_write_o, if_stall_o} !== 3'b110) begin nfail++;
      $display("FAIL branch_flush: got flush/pc/stall=%b want 110", {if_flush_o, pc_write_o, if_stall_o}); end
  endtask

  task automatic test_mem_wait();
    int starts = 0;
    int stalls = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    starts += int'(mem_start_o); stalls += int'(mem_stall_o);
    ncmp++; if (obs !== 7'b0000110) begin nfail++; $display("FAIL mem_launch: got %b want %b", obs, 7'b0000110); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 3, 3, 0, 0, 1, 1, 0);
      starts += int'(mem_start_o); stalls += int'(mem_stall_o);
      ncmp++; if (obs !== 7'b0000100) begin nfail++; $display("FAIL mem_wait_%0d: got %b want %b", i, obs, 7'b0000100); end
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    starts += int'(mem_start_o);
    ncmp++; if (obs !== 7'b1010000) begin nfail++; $display("FAIL mem_ack_cycle: got %b want %b", obs, 7'b1010000); end
    ncmp++; if (stalls !== 3) begin nfail++; $display("FAIL mem_stall_cycles: got %0d want 3", stalls); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    starts += int'(mem_start_o);
    ncmp++; if (obs !== 7'b1000000) begin nfail++; $display("FAIL after_ack_run: got %b want %b", obs, 7'b1000000); end
    ncmp++; if (starts !== 1) begin nfail++; $display("FAIL mem_start_pulses: got %0d want 1", starts); end
    drive(1, 1, 2, 2, 0, 0, 0, 1, 1);
    ncmp++; if (obs !== 7'b0101000) begin nfail++; $display("FAIL zero_wait_hit: got %b want %b", obs, 7'b0101000); end
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    ncmp++; if (mem_start_o !== 1'b1) begin nfail++; $display("FAIL to_launch: got %b want 1", mem_start_o); end
    for (int i = 0; i < TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      ncmp++; if ({mem_stall_o, err_o} !== 2'b10) begin nfail++;
        $display("FAIL to_wait_%0d: got stall/err=%b want 10", i, {mem_stall_o, err_o}); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 1, (i == 1));
      ncmp++; if (obs !== 7'b0000101) begin nfail++; $display("FAIL halt_%0d: got %b want %b", i, obs, 7'b0000101); end
    end
    @(negedge clk); #2; rst_i = 1'b1; #1;
    ncmp++; if ({err_o, mem_stall_o} !== 2'b00) begin nfail++;
      $display("FAIL async_reset: got err/stall=%b want 00", {err_o, mem_stall_o}); end
    @(negedge clk); rst_i = 1'b0; #1;
    ncmp++; if (obs !== 7'b0) begin nfail++; $display("FAIL post_reset_idle: got %b want %b", obs, 7'b0); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ncmp++; if (obs !== 7'b1000000) begin nfail++; $display("FAIL post_reset_run: got %b want %b", obs, 7'b1000000); end
  endtask

  task automatic test_random();
    logic st, rq;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 49) begin
        @(negedge clk); rst_i = 1'b1; #1;
        ncmp++; if (obs !== model_out()) begin nfail++; $display("FAIL rand_reset_%0d: got %b want %b", n, obs, model_out()); end
        @(negedge clk); rst_i = 1'b0;
      end
      rq = ($urandom_range(0, 9) < 4);
      st = rq ? 1'b1 : ($urandom_range(0, 15) != 0);
      drive(st, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), rq,
            ($urandom_range(0, 9) < 3));
      ncmp++; if (obs !== model_out()) begin nfail++; $display("FAIL rand_%0d: got %b want %b", n, obs, model_out()); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hazard_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives PC write-enable, the IF/ID stall and flush inputs, and the ID/EX bubble insertion. It freezes the whole pipeline while a data-memory access is outstanding and supervises that access with a timeout.
- Priority: memory freeze > load-use stall > taken-branch flush.

Parameters:
- REG_W, 5, register index width.
- TIMEOUT, 255, maximum cycles in MEM_WAIT before fault.
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  processor run enable.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rd_i  in  REG_W  destination register of ID/EX.
- ifid_rs1_i  in  REG_W  rs1 of instruction in IF/ID.
- ifid_rs2_i  in  REG_W  rs2 of instruction in IF/ID.
- ifid_uses_rs2_i  in  1  IF/ID instruction reads rs2.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- dmem_req_i  in  1  MEM stage has an access pending (level).
- dmem_ack_i  in  1  data memory completes access (1-cycle pulse).
- pc_write_o  out  1  PC register write enable.
- if_stall_o  out  1  hold IF/ID.
- if_flush_o  out  1  zero IF/ID.
- id_bubble_o  out  1  force zero control into ID/EX.
- mem_stall_o  out  1  freeze all pipeline registers and PC.
- mem_start_o  out  1  one-cycle access launch to data memory.
- err_o  out  1  sticky memory-timeout fault.

Behaviour:
- Reset: state=IDLE, counter=0, err_o=0. All outputs read 0 during reset.
- Outputs are combinational from state and inputs (same-cycle effect). State, counter and err_o are registered.
- States:
  - IDLE: all outputs 0 except err_o. Go to RUN when start_i=1.
  - RUN: normal operation. If start_i=0, go to IDLE (outputs still evaluated this cycle).
  - MEM_WAIT: memory access outstanding.
  - HALT: timeout fault.
- hazard = idex_memread_i & (idex_rd_i!=0) & ((idex_rd_i==ifid_rs1_i) | (ifid_uses_rs2_i & idex_rd_i==ifid_rs2_i)).
- RUN, dmem_req_i=1 & dmem_ack_i=0:
  - mem_stall_o=1, mem_start_o=1, pc_write_o=0; other outputs 0.
  - Next state MEM_WAIT, counter=0.
- RUN, dmem_req_i=1 & dmem_ack_i=1 (zero-wait hit): treated as no memory stall.
- RUN, no memory stall, hazard=1:
  - pc_write_o=0, if_stall_o=1, id_bubble_o=1, if_flush_o=0.
  - A simultaneous branch_taken_i is ignored; ID re-resolves the branch next cycle.
- RUN, no memory stall, hazard=0, branch_taken_i=1: pc_write_o=1, if_flush_o=1.
- RUN, otherwise: pc_write_o=1, all other outputs 0.
- MEM_WAIT:
  - mem_stall_o=1 and pc_write_o=0 every cycle; hazard and branch inputs ignored; counter increments each cycle.
  - dmem_ack_i=1: that cycle mem_stall_o=0 and RUN rules apply with mem_start_o forced 0. Next state RUN.
  - Counter reaches TIMEOUT without ack: next state HALT, err_o set.
  - start_i=0: ignored; the access must complete first.
- HALT: mem_stall_o=1, pc_write_o=0, err_o=1. Left only by reset.
- Reset mid-access: returns immediately to IDLE. No mem_start_o is reissued after reset.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0], both reset to 0 and wrapping at 2^32.
  - stall_cnt_o increments each cycle pc_write_o=0 in RUN or MEM_WAIT.
  - flush_cnt_o increments each cycle if_flush_o=1.
- Undefined: ports and counters absent; no other behaviour changes.

Test Plan:
- Reset, start_i=1 one cycle later, no hazards -> pc_write_o=1 from the first RUN cycle; all stall/flush outputs 0.
- idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5, ifid_uses_rs2_i=1 -> pc_write_o=0, if_stall_o=1, id_bubble_o=1 for that cycle. Same stimulus with idex_rd_i=0 -> no stall.
- Hazard and branch_taken_i=1 in the same cycle -> stall only, if_flush_o=0. Next cycle branch_taken_i=1, no hazard -> if_flush_o=1, pc_write_o=1.
- dmem_req_i=1 with ack after 3 cycles -> mem_start_o pulses exactly once. mem_stall_o=1 for 3 cycles, 0 in the ack cycle. Branch pulses during the wait produce no flush.
- TIMEOUT=4, dmem_req_i held, no ack -> HALT after 4 MEM_WAIT cycles. err_o=1 and mem_stall_o=1 persist until rst_i; rst_i clears both asynchronously.
